// File: rtl/match_resp_rob_pkg.sv
// Shared defaults and helpers for the match response reorder buffer.
// A response tag is {slot, lane}, with the slot field above the lane field.
package match_resp_rob_pkg;

  localparam int LAZY_LEN         = 4;  // lanes per lazy-match request group
  localparam int NUM_MATCH_REQ_CH = 2;  // match_pe response channels
  localparam int MATCH_RESP_DEPTH = 4;  // outstanding group slots
  localparam int MATCH_LEN_WIDTH  = 8;  // match length width

  // Width of one {slot, lane} response tag.
  function automatic int tag_width(input int slot_bits, input int lane_bits);
    return slot_bits + lane_bits;
  endfunction

endpackage

// File: rtl/match_resp_slot.sv
// Storage for one outstanding request group: allocation bit, lane strobe,
// per-lane done flags and accumulated per-lane match lengths.
module match_resp_slot #(
  parameter int L  = 4,
  parameter int ML = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,       // group allocated into this slot
  input  logic [L-1:0]    load_strb_i,  // lanes expecting a response
  input  logic [L-1:0]    set_i,        // lanes receiving an accepted response
  input  logic [L*ML-1:0] set_len_i,    // lengths for set lanes, zero elsewhere
  input  logic            clear_i,      // group released to job_pe
  output logic            alloc_o,
  output logic [L-1:0]    strb_o,
  output logic [L-1:0]    done_o,
  output logic [L*ML-1:0] len_o,
  output logic            complete_o
);

  logic            alloc_q, alloc_d;
  logic [L-1:0]    strb_q, strb_d;
  logic [L-1:0]    done_q, done_d;
  logic [L*ML-1:0] len_q, len_d;

  // Next state: load wins over clear (they never target the same slot in one
  // cycle), otherwise accumulate accepted responses into the lanes.
  always_comb begin
    alloc_d = alloc_q;
    strb_d  = strb_q;
    done_d  = done_q;
    len_d   = len_q;
    if (load_i) begin
      alloc_d = 1'b1;
      strb_d  = load_strb_i;
      done_d  = ~load_strb_i;  // unstrobed lanes never wait for a response
      len_d   = '0;
    end else if (clear_i) begin
      alloc_d = 1'b0;
      strb_d  = '0;
      done_d  = '0;
      len_d   = '0;
    end else begin
      done_d = done_q | set_i;
      len_d  = len_q | set_len_i;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= 1'b0;
      strb_q  <= '0;
      done_q  <= '0;
      len_q   <= '0;
    end else begin
      alloc_q <= alloc_d;
      strb_q  <= strb_d;
      done_q  <= done_d;
      len_q   <= len_d;
    end
  end

  assign alloc_o    = alloc_q;
  assign strb_o     = strb_q;
  assign done_o     = done_q;
  assign len_o      = len_q;
  assign complete_o = &done_q;

endmodule

// File: rtl/match_resp_rob.sv
// Multi-group response collector for one job_pe. Groups are allocated into a
// ring of D slots, filled by tagged responses from C channels in any order,
// and released strictly in allocation order.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready in the same cycle, and a
// source holding valid high keeps its payload stable until ready is seen.
module match_resp_rob
  import match_resp_rob_pkg::*;
#(
  parameter int JOB_PE_IDX = 0,
  parameter int L          = LAZY_LEN,
  parameter int C          = NUM_MATCH_REQ_CH,
  parameter int D          = MATCH_RESP_DEPTH,
  parameter int ML         = MATCH_LEN_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_group_valid,
  output logic                               req_group_ready,
  input  logic [L-1:0]                       req_group_strb,
  output logic [$clog2(D)-1:0]               req_group_slot,
  input  logic [C-1:0]                       resp_valid,
  output logic [C-1:0]                       resp_ready,
  input  logic [C*($clog2(D)+$clog2(L))-1:0] resp_tag,
  input  logic [C*ML-1:0]                    resp_match_len,
  output logic                               resp_group_valid,
  input  logic                               resp_group_ready,
  output logic [L-1:0]                       resp_group_strb,
  output logic [L*ML-1:0]                    resp_group_match_len,
  output logic [$clog2(D):0]                 occupancy,
  output logic                               err_stray,
  output logic                               err_collide
);

  // L and D are powers of two, so lane and slot fields index exactly.
  localparam int SLOT_BITS = $clog2(D);
  localparam int LANE_BITS = $clog2(L);
  localparam int TW        = tag_width(SLOT_BITS, LANE_BITS);

  logic [SLOT_BITS-1:0] head_q, head_d;
  logic [SLOT_BITS-1:0] tail_q, tail_d;
  logic [SLOT_BITS:0]   occ_q, occ_d;
  logic                 err_stray_q, err_stray_d;
  logic                 err_collide_q, err_collide_d;

  logic                 alloc_fire;
  logic                 rel_fire;

  logic [D-1:0]         alloc_w;
  logic [D-1:0]         complete_w;
  logic [L-1:0]         strb_w    [D];
  logic [L-1:0]         done_w    [D];
  logic [L*ML-1:0]      len_w     [D];
  logic [D-1:0]         load_v;
  logic [D-1:0]         clear_v;
  logic [L-1:0]         set_v     [D];
  logic [L*ML-1:0]      set_len_v [D];

  logic [SLOT_BITS-1:0] ch_slot [C];
  logic [LANE_BITS-1:0] ch_lane [C];
  logic [ML-1:0]        ch_len  [C];
  logic [C-1:0]         accept;
  logic [C-1:0]         cand;
  logic [C-1:0]         win;
  logic [C-1:0]         stray_v;
  logic [C-1:0]         coll_v;

  // Split each channel's tag into its slot and lane fields.
  for (genvar c = 0; c < C; c++) begin : g_ch
    assign ch_slot[c] = resp_tag[c*TW+LANE_BITS +: SLOT_BITS];
    assign ch_lane[c] = resp_tag[c*TW +: LANE_BITS];
    assign ch_len[c]  = resp_match_len[c*ML +: ML];
  end

  // Slot ring: load at tail on allocation, clear at head on release.
  for (genvar s = 0; s < D; s++) begin : g_slot
    assign load_v[s]  = alloc_fire & (tail_q == SLOT_BITS'(s));
    assign clear_v[s] = rel_fire & (head_q == SLOT_BITS'(s));
    match_resp_slot #(.L(L), .ML(ML)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_v[s]),
      .load_strb_i (req_group_strb),
      .set_i       (set_v[s]),
      .set_len_i   (set_len_v[s]),
      .clear_i     (clear_v[s]),
      .alloc_o     (alloc_w[s]),
      .strb_o      (strb_w[s]),
      .done_o      (done_w[s]),
      .len_o       (len_w[s]),
      .complete_o  (complete_w[s])
    );
  end

  // Classify responses: a candidate targets an allocated, strobed, not yet
  // done lane; among candidates on one {slot,lane} the lowest channel wins.
  // A head slot being released is fully done, so any hit on it is stray.
  always_comb begin
    accept  = resp_valid & resp_ready;
    cand    = '0;
    win     = '0;
    stray_v = '0;
    coll_v  = '0;
    for (int c = 0; c < C; c++) begin
      cand[c] = accept[c] & alloc_w[ch_slot[c]] &
                strb_w[ch_slot[c]][ch_lane[c]] & ~done_w[ch_slot[c]][ch_lane[c]];
    end
    for (int c = 0; c < C; c++) begin
      win[c]     = cand[c];
      stray_v[c] = accept[c] & ~cand[c];
      for (int j = 0; j < C; j++) begin
        if (j < c && cand[j] && cand[c] &&
            ch_slot[j] == ch_slot[c] && ch_lane[j] == ch_lane[c]) begin
          win[c]    = 1'b0;
          coll_v[c] = 1'b1;
        end
      end
    end
  end

  // Decode winning responses into per-slot lane set vectors and lengths.
  always_comb begin
    for (int s = 0; s < D; s++) begin
      set_v[s]     = '0;
      set_len_v[s] = '0;
    end
    for (int c = 0; c < C; c++) begin
      if (win[c]) begin
        set_v[ch_slot[c]][ch_lane[c]]                      = 1'b1;
        set_len_v[ch_slot[c]][int'(ch_lane[c])*ML +: ML] = ch_len[c];
      end
    end
  end

  // Pointer, occupancy and error-pulse next state.
  always_comb begin
    alloc_fire    = req_group_valid & req_group_ready;
    rel_fire      = resp_group_valid & resp_group_ready;
    tail_d        = alloc_fire ? tail_q + 1'b1 : tail_q;
    head_d        = rel_fire ? head_q + 1'b1 : head_q;
    occ_d         = occ_q;
    case ({alloc_fire, rel_fire})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    err_stray_d   = |stray_v;
    err_collide_d = |coll_v;
  end

  // Control registers; reset silently discards every outstanding group.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      err_stray_q   <= 1'b0;
      err_collide_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
      err_stray_q   <= err_stray_d;
      err_collide_q <= err_collide_d;
    end
  end

  // Full/empty come from occupancy, never from pointer equality.
  assign req_group_ready      = (occ_q != (SLOT_BITS+1)'(D));
  assign req_group_slot       = tail_q;
  assign resp_ready           = {C{~rst}};
  assign resp_group_valid     = alloc_w[head_q] & complete_w[head_q];
  assign resp_group_strb      = strb_w[head_q];
  assign resp_group_match_len = len_w[head_q];
  assign occupancy            = occ_q;
  assign err_stray            = err_stray_q;
  assign err_collide          = err_collide_q;

`ifdef JOB_PE_DEBUG_LOG
  // Allocation and release trace for this job_pe.
  always @(posedge clk) begin
    if (!rst && alloc_fire)
      $display("job_pe[%0d] rob alloc slot=%0d strb=%b", JOB_PE_IDX, tail_q, req_group_strb);
    if (!rst && rel_fire)
      $display("job_pe[%0d] rob release slot=%0d len=%h", JOB_PE_IDX, head_q, resp_group_match_len);
  end
`endif

endmodule

// File: tb/tb_match_resp_rob.sv
// Bench for match_resp_rob with L=4, C=2, D=4, ML=8: a table of directed
// cycles with hand-computed results, then hand-written reset, backpressure
// and streaming sequences.
module tb_match_resp_rob;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_group_valid;
  logic        req_group_ready;
  logic [3:0]  req_group_strb;
  logic [1:0]  req_group_slot;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [7:0]  resp_tag;
  logic [15:0] resp_match_len;
  logic        resp_group_valid;
  logic        resp_group_ready;
  logic [3:0]  resp_group_strb;
  logic [31:0] resp_group_match_len;
  logic [2:0]  occupancy;
  logic        err_stray;
  logic        err_collide;

  int errors = 0;
  int checks = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  match_resp_rob #(.JOB_PE_IDX(0), .L(4), .C(2), .D(4), .ML(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_group_valid      (req_group_valid),
    .req_group_ready      (req_group_ready),
    .req_group_strb       (req_group_strb),
    .req_group_slot       (req_group_slot),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_tag             (resp_tag),
    .resp_match_len       (resp_match_len),
    .resp_group_valid     (resp_group_valid),
    .resp_group_ready     (resp_group_ready),
    .resp_group_strb      (resp_group_strb),
    .resp_group_match_len (resp_group_match_len),
    .occupancy            (occupancy),
    .err_stray            (err_stray),
    .err_collide          (err_collide)
  );

  typedef struct {
    logic        req_v;
    logic [3:0]  req_strb;
    logic [1:0]  rv;
    logic [3:0]  tag0;
    logic [7:0]  len0;
    logic [3:0]  tag1;
    logic [7:0]  len1;
    logic        gready;
    logic        e_valid;
    logic [3:0]  e_strb;
    logic [31:0] e_len;
    logic [2:0]  e_occ;
    logic [1:0]  e_slot;
    logic        e_rdy;
    logic        e_stray;
    logic        e_coll;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  logic [35:0] exp_q [$];
  logic [11:0] pend_q [$];

  function automatic vec_t mk(
    input logic req_v, input logic [3:0] req_strb, input logic [1:0] rv,
    input logic [3:0] tag0, input logic [7:0] len0,
    input logic [3:0] tag1, input logic [7:0] len1, input logic gready,
    input logic e_valid, input logic [3:0] e_strb, input logic [31:0] e_len,
    input logic [2:0] e_occ, input logic [1:0] e_slot, input logic e_rdy,
    input logic e_stray, input logic e_coll);
    vec_t v;
    v.req_v = req_v;   v.req_strb = req_strb; v.rv = rv;
    v.tag0 = tag0;     v.len0 = len0;         v.tag1 = tag1;  v.len1 = len1;
    v.gready = gready; v.e_valid = e_valid;   v.e_strb = e_strb;
    v.e_len = e_len;   v.e_occ = e_occ;       v.e_slot = e_slot;
    v.e_rdy = e_rdy;   v.e_stray = e_stray;   v.e_coll = e_coll;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks.
  task automatic idle_inputs();
    req_group_valid  = 1'b0;
    req_group_strb   = '0;
    resp_valid       = '0;
    resp_tag         = '0;
    resp_match_len   = '0;
    resp_group_ready = 1'b0;
  endtask

  task automatic drive(input logic req_v, input logic [3:0] strb, input logic [1:0] rv,
                       input logic [3:0] t0, input logic [7:0] l0,
                       input logic [3:0] t1, input logic [7:0] l1, input logic gready);
    req_group_valid  = req_v;
    req_group_strb   = strb;
    resp_valid       = rv;
    resp_tag         = {t1, t0};
    resp_match_len   = {l1, l0};
    resp_group_ready = gready;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("resp_ready_in_reset", resp_ready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_valid", resp_group_valid, 1'b0);
    chk("rst_slot", req_group_slot, 2'd0);
    chk("rst_ready", req_group_ready, 1'b1);
    chk("rst_strb", resp_group_strb, 4'h0);
    chk("rst_len", resp_group_match_len, 32'h0);
    chk("rst_errs", {err_stray, err_collide}, 2'b00);
    chk("rst_resp_ready", resp_ready, 2'b11);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] item;
    logic [31:0] lens;
    logic [35:0] expv;
    logic        fire_a;
    logic        fire_r;
    logic [1:0]  tail_m;
    int          issued;
    int          released;

    // Directed table, starting from reset (tag = {slot,lane}).
    tbl[0]  = mk(1, 4'hF, 2'b00, 0, 8'h00, 0, 8'h00, 0, 0, 4'hF, 32'h00000000, 1, 1, 1, 0, 0);
    tbl[1]  = mk(0, 4'h0, 2'b11, 2, 8'h09, 0, 8'h05, 0, 0, 4'hF, 32'h00090005, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 4'h0, 2'b11, 1, 8'h03, 3, 8'h07, 0, 1, 4'hF, 32'h07090305, 1, 1, 1, 0, 0);
    tbl[3]  = mk(0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 0, 4'h0, 32'h00000000, 0, 1, 1, 0, 0);
    tbl[4]  = mk(1, 4'hF, 2'b00, 0, 8'h00, 0, 8'h00, 0, 0, 4'hF, 32'h00000000, 1, 2, 1, 0, 0);
    tbl[5]  = mk(1, 4'h3, 2'b00, 0, 8'h00, 0, 8'h00, 0, 0, 4'hF, 32'h00000000, 2, 3, 1, 0, 0);
    tbl[6]  = mk(0, 4'h0, 2'b11, 8, 8'h11, 9, 8'h22, 0, 0, 4'hF, 32'h00000000, 2, 3, 1, 0, 0);
    tbl[7]  = mk(0, 4'h0, 2'b11, 4, 8'h01, 5, 8'h02, 0, 0, 4'hF, 32'h00000201, 2, 3, 1, 0, 0);
    tbl[8]  = mk(0, 4'h0, 2'b11, 6, 8'h03, 7, 8'h04, 1, 1, 4'hF, 32'h04030201, 2, 3, 1, 0, 0);
    tbl[9]  = mk(0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 1, 4'h3, 32'h00002211, 1, 3, 1, 0, 0);
    tbl[10] = mk(0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 0, 4'h0, 32'h00000000, 0, 3, 1, 0, 0);
    tbl[11] = mk(1, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00, 0, 1, 4'h0, 32'h00000000, 1, 0, 1, 0, 0);
    tbl[12] = mk(1, 4'h1, 2'b00, 0, 8'h00, 0, 8'h00, 0, 1, 4'h0, 32'h00000000, 2, 1, 1, 0, 0);
    tbl[13] = mk(1, 4'h1, 2'b00, 0, 8'h00, 0, 8'h00, 0, 1, 4'h0, 32'h00000000, 3, 2, 1, 0, 0);
    tbl[14] = mk(1, 4'h1, 2'b00, 0, 8'h00, 0, 8'h00, 0, 1, 4'h0, 32'h00000000, 4, 3, 0, 0, 0);
    tbl[15] = mk(1, 4'h1, 2'b00, 0, 8'h00, 0, 8'h00, 1, 0, 4'h1, 32'h00000000, 3, 3, 1, 0, 0);
    tbl[16] = mk(1, 4'h1, 2'b01, 0, 8'hAA, 0, 8'h00, 0, 1, 4'h1, 32'h000000AA, 4, 0, 0, 0, 0);
    tbl[17] = mk(0, 4'h0, 2'b11, 0, 8'h55, 6, 8'h01, 0, 1, 4'h1, 32'h000000AA, 4, 0, 0, 1, 0);
    tbl[18] = mk(0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 0, 4'h1, 32'h00000000, 3, 0, 1, 0, 0);
    tbl[19] = mk(0, 4'h0, 2'b11, 4, 8'h04, 4, 8'h06, 0, 1, 4'h1, 32'h00000004, 3, 0, 1, 0, 1);
    tbl[20] = mk(0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 0, 4'h1, 32'h00000000, 2, 0, 1, 0, 0);

    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].req_v, tbl[i].req_strb, tbl[i].rv, tbl[i].tag0, tbl[i].len0,
            tbl[i].tag1, tbl[i].len1, tbl[i].gready);
      chk($sformatf("row%0d_valid", i), resp_group_valid, tbl[i].e_valid);
      chk($sformatf("row%0d_strb", i), resp_group_strb, tbl[i].e_strb);
      chk($sformatf("row%0d_len", i), resp_group_match_len, tbl[i].e_len);
      chk($sformatf("row%0d_occ", i), occupancy, tbl[i].e_occ);
      chk($sformatf("row%0d_slot", i), req_group_slot, tbl[i].e_slot);
      chk($sformatf("row%0d_ready", i), req_group_ready, tbl[i].e_rdy);
      chk($sformatf("row%0d_stray", i), err_stray, tbl[i].e_stray);
      chk($sformatf("row%0d_collide", i), err_collide, tbl[i].e_coll);
    end

    // Partial strobe, stray to unallocated slot, backpressure, reset.
    do_reset();
    drive(1, 4'h5, 2'b00, 0, 8'h00, 0, 8'h00, 0);
    chk("part_slot", req_group_slot, 2'd1);
    chk("part_occ", occupancy, 3'd1);
    drive(0, 4'h0, 2'b01, 4'd12, 8'h77, 0, 8'h00, 0);
    chk("unalloc_stray", err_stray, 1'b1);
    chk("unalloc_occ", occupancy, 3'd1);
    chk("unalloc_valid", resp_group_valid, 1'b0);
    chk("unalloc_len", resp_group_match_len, 32'h0);
    drive(0, 4'h0, 2'b11, 4'd0, 8'h12, 4'd2, 8'h34, 0);
    chk("part_valid", resp_group_valid, 1'b1);
    chk("part_strb", resp_group_strb, 4'h5);
    chk("part_len", resp_group_match_len, 32'h00340012);
    chk("part_stray_clear", err_stray, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'h0, 2'b00, 0, 8'h00, 0, 8'h00, 0);
      chk($sformatf("bp%0d_valid", k), resp_group_valid, 1'b1);
      chk($sformatf("bp%0d_strb", k), resp_group_strb, 4'h5);
      chk($sformatf("bp%0d_len", k), resp_group_match_len, 32'h00340012);
    end
    drive(1, 4'hF, 2'b00, 0, 8'h00, 0, 8'h00, 0);
    chk("two_outstanding_occ", occupancy, 3'd2);
    do_reset();
    drive(1, 4'hF, 2'b00, 0, 8'h00, 0, 8'h00, 0);
    chk("post_rst_alloc_next_slot", req_group_slot, 2'd1);
    chk("post_rst_alloc_occ", occupancy, 3'd1);
    chk("post_rst_head_strb", resp_group_strb, 4'hF);

    // Stream of 20 groups with shuffled responses and random backpressure.
    do_reset();
    tail_m   = 2'd0;
    issued   = 0;
    released = 0;
    for (int cyc = 0; cyc < 600 && released < 20; cyc++) begin
      req_group_valid  = (issued < 20);
      req_group_strb   = 4'hF;
      resp_valid       = '0;
      resp_tag         = '0;
      resp_match_len   = '0;
      for (int ch = 0; ch < 2; ch++) begin
        if (pend_q.size() > 0) begin
          item = pend_q.pop_front();
          resp_valid[ch]            = 1'b1;
          resp_tag[ch*4 +: 4]       = item[11:8];
          resp_match_len[ch*8 +: 8] = item[7:0];
        end
      end
      resp_group_ready = 1'($urandom_range(0, 1));
      fire_a = req_group_valid && req_group_ready;
      fire_r = resp_group_valid && resp_group_ready;
      if (fire_r) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_group", 1'b1, 1'b0);
        end else begin
          expv = exp_q.pop_front();
          chk($sformatf("stream_grp%0d", released), {resp_group_strb, resp_group_match_len}, expv);
        end
        released++;
      end
      if (fire_a) begin
        for (int ln = 0; ln < 4; ln++) begin
          lens[ln*8 +: 8] = 8'($urandom_range(1, 255));
          if ($urandom_range(0, 1) == 1)
            pend_q.push_front({tail_m, 2'(ln), lens[ln*8 +: 8]});
          else
            pend_q.push_back({tail_m, 2'(ln), lens[ln*8 +: 8]});
        end
        exp_q.push_back({4'hF, lens});
        tail_m = tail_m + 2'd1;
        issued++;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("stream_released", released, 20);
    chk("stream_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_resp_rob.md
Name: match_resp_rob

Overview:
- Multi-group successor of the single-group response collector in the match engine.
- Tracks up to D outstanding lazy-match request groups per job_pe. Each group has L lanes.
- Accepts tagged responses from C match_pe channels in any order, across any outstanding group.
- Releases completed groups to job_pe strictly in allocation order, with per-lane strobe and match lengths.

Parameters:
JOB_PE_IDX, 0, index used in debug log messages only
L, `LAZY_LEN, lanes per request group
C, `NUM_MATCH_REQ_CH, number of response channels
D, 4, outstanding group slots (power of two, >=2)
LANE_BITS, `LAZY_LEN_LOG2, lane index width
SLOT_BITS, $clog2(D), slot index width
ML, `MATCH_LEN_WIDTH, match length width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_group_valid  in  1  new request group issued
req_group_ready  out  1  slot free for allocation
req_group_strb  in  L  lanes that expect a response
req_group_slot  out  SLOT_BITS  slot assigned to this group; match_pe tags carry it
resp_valid  in  C  per-channel response valid
resp_ready  out  C  per-channel response ready
resp_tag  in  C*(SLOT_BITS+LANE_BITS)  {slot, lane} per channel
resp_match_len  in  C*ML  per-channel match length
resp_group_valid  out  1  head group complete
resp_group_ready  in  1  job_pe accepts group
resp_group_strb  out  L  original strobe of the released group
resp_group_match_len  out  L*ML  lane match lengths; 0 for unstrobed lanes
occupancy  out  SLOT_BITS+1  allocated slots
err_stray  out  1  one-cycle pulse: response to an unallocated slot, an unstrobed lane, or an already-done lane
err_collide  out  1  one-cycle pulse: two channels hit the same {slot,lane} in one cycle

Behaviour:
- Reset (rst high at a clk edge):
  - Clears all slots, head/tail pointers and occupancy to 0.
  - Outputs after reset: req_group_ready=1, resp_ready=0 during the reset cycle and 1 afterwards, resp_group_valid=0, all data outputs 0, err_* = 0.
  - Reset mid-operation discards every outstanding group silently.
- Per-slot state: alloc bit, strb[L], done[L], len[L*ML].
- Allocation:
  - req_group_ready = (occupancy != D). It does not depend on a same-cycle release.
  - req_group_slot = tail, combinational.
  - On fire: slot[tail] gets alloc=1, strb=req_group_strb, done=~req_group_strb, len=0. Tail increments mod D.
- Response accept: resp_ready is all ones outside reset, so accept = resp_valid.
- Response classification: each accepted channel whose slot is allocated and whose lane has strb=1 and done=0 is valid. It sets done and ORs its length into that lane, visible the next cycle.
  - Invalid responses are dropped and pulse err_stray in the next cycle.
  - Multiple channels hitting the same {slot,lane} in one cycle: the lowest-index channel wins, the others are dropped, and err_collide pulses.
- Release:
  - resp_group_valid = alloc[head] & (&done[head]), registered state only.
  - Minimum latency: last response accepted at edge N gives valid high after edge N. An all-zero strobe group becomes valid the cycle after allocation.
  - Outputs come from slot[head]. They hold stable while valid=1 and ready=0.
  - On valid&ready: alloc[head] clears, head increments mod D.
- Ordering: a later group complete before the head waits. No bypass.
- Simultaneous events:
  - Allocate and release in the same cycle: occupancy unchanged.
  - Full and releasing: still not ready this cycle.
  - A response to the head lane in its release cycle is impossible for correct traffic; if it occurs, it counts as stray.
- Pointer wrap: indices wrap at D.
  - Full and empty are distinguished by occupancy, not by pointer equality.
- Debug: under JOB_PE_DEBUG_LOG, $display allocation and release events with JOB_PE_IDX.

Decomposition:
- Shared header (parameters.vh/util.vh): tag layout macros (SLOT field above LANE field) and default D as `MATCH_RESP_DEPTH.
- Sub-module match_resp_slot: one slot's storage, with load on allocate, per-lane set/OR update from a decoded lane vector, clear on release, and a complete flag. Instantiated D times.
- The top level holds the pointers, the channel-to-lane decode, collision arbitration and the output mux.

Test Plan (L=4, C=2, D=4, ML=8):
- Single group: allocate strb=4'b1111 (slot 0); ch0 tag{0,2}=9 and ch1 tag{0,0}=5, then ch0 {0,1}=3 and ch1 {0,3}=7 -> valid one cycle later, match_len lanes[3:0]={7,9,3,5}, strb=1111.
- Out-of-order completion: allocate groups A (slot 0) and B (slot 1); complete B fully first -> no valid. Complete A -> A released, then B released the next cycle with ready held high.
- Full and wrap: allocate 4 groups -> req_group_ready=0, occupancy=4.
  - Release one -> ready returns the next cycle and the 5th allocation gets slot 0.
  - Run 20 groups continuously -> in-order output with no loss.
- Partial and empty strobes: strb=4'b0101 needs only lanes 0 and 2 -> released with lanes 1 and 3 at 0. strb=0 -> valid one cycle after fire.
- Errors:
  - Response to an unallocated slot 3 -> err_stray pulses, no state change.
  - Both channels hit tag{0,1} with lengths 4 and 6 -> lane keeps 4 and err_collide pulses.
- Backpressure and reset: hold resp_group_ready=0 for 5 cycles -> outputs stable. Assert rst with 2 groups outstanding -> occupancy=0, valid=0, next allocation gets slot 0.
